// File: rtl/clock_mode_controller.sv
// clock_mode_controller: debounced button FSM selecting clock/adjust/alarm modes with adjust strobes
module clock_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ALARM_TIMEOUT = 12000
) (
  input  logic       clk200Hz,
  input  logic       rst,
  input  logic       btnC,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       alarm_match,
  output logic       en_en,
  output logic       adjust_en_hour,
  output logic       adjust_en_min,
  output logic       adjust_alarm_en_hour,
  output logic       adjust_alarm_en_min,
  output logic       updown,
  output logic       segment_display_flag,
  output logic       alarm_active,
  output logic [5:0] mode_led
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [5:0] {
    CLOCK     = 6'b000001,
    ADJ_HOUR  = 6'b000010,
    ADJ_MIN   = 6'b000100,
    ADJ_AHOUR = 6'b001000,
    ADJ_AMIN  = 6'b010000,
    ALARM     = 6'b100000
  } state_t;
  state_t state, state_n;
  logic [4:0] sync1, sync2, deb, deb_q, pulse;
  logic [CW-1:0] cnt [5];
  logic [3:0] stb, stb_n;
  logic updown_n, am_q, am_q2;
  logic [13:0] tcnt;
  // button bit order: 0=C 1=U 2=D 3=L 4=R
  always_ff @(posedge clk200Hz) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb <= '0;
      deb_q <= '0;
      pulse <= '0;
      cnt <= '{default: '0};
    end else begin
      sync1 <= {btnR, btnL, btnD, btnU, btnC};
      sync2 <= sync1;
      deb_q <= deb;
      pulse <= deb & ~deb_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk200Hz) begin
    if (!rst) begin
      state <= CLOCK;
      stb <= '0;
      updown <= 1'b1;
      am_q <= 1'b0;
      am_q2 <= 1'b0;
      tcnt <= '0;
    end else begin
      state <= state_n;
      stb <= stb_n;
      updown <= updown_n;
      am_q <= alarm_match;
      am_q2 <= am_q;
      tcnt <= (state == ALARM) ? tcnt + 1'b1 : '0;
    end
  end
  always_comb begin
    state_n = state;
    stb_n = '0;
    updown_n = updown;
    if (state == ALARM)
      state_n = (|pulse || tcnt == 14'(ALARM_TIMEOUT - 1)) ? CLOCK : ALARM;
    else if (state == CLOCK)
      state_n = pulse[0] ? ADJ_HOUR : (am_q & ~am_q2) ? ALARM : CLOCK;
    else if (pulse[0])
      state_n = CLOCK;
    else if (pulse[3] | pulse[4])
      state_n = (pulse[3] & pulse[4]) ? state :
                pulse[4] ? state_t'({1'b0, state[3:1], state[4], 1'b0}) :
                           state_t'({1'b0, state[1], state[4:2], 1'b0});
    else if (pulse[1] ^ pulse[2]) begin
      stb_n = state[4:1];
      updown_n = pulse[1];
    end
  end
  assign {adjust_alarm_en_min, adjust_alarm_en_hour, adjust_en_min, adjust_en_hour} = stb;
  assign mode_led = state;
  assign en_en = state[0] | state[5];
  assign segment_display_flag = state[3] | state[4];
  assign alarm_active = state[5];
endmodule

// File: doc/clock_mode_controller.md
CLOCK_MODE_CONTROLLER -- requirements
Module: clock_mode_controller

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples needed to accept a button change (20 ms at 200 Hz).
REQ-002 The block SHALL have parameter ALARM_TIMEOUT, default 12000: cycles the alarm stays active without dismissal (60 s at 200 Hz).
REQ-003 The block SHALL use one clock and a synchronous, active-low reset, with ports:
- clk200Hz, input, 1, sole clock; all state changes on its rising edge.
- rst, input, 1, synchronous active-low reset.
REQ-004 The block SHALL have these other ports:
- btnC, btnU, btnD, btnL, btnR, input, 1 each, raw asynchronous push buttons, active-high.
- alarm_match, input, 1, high while the alarm time equals the clock time.
- en_en, output, 1, clock count enable.
- adjust_en_hour, adjust_en_min, adjust_alarm_en_hour, adjust_alarm_en_min, output, 1 each, one-cycle adjust strobes.
- updown, output, 1, adjust direction: 1 = increment, 0 = decrement.
- segment_display_flag, output, 1, 1 = display shows the alarm time.
- alarm_active, output, 1, alarm ringing indicator.
- mode_led, output, 6, one-hot copy of the current state.

Function
REQ-005 Each button SHALL pass through a 2-flop synchronizer, then a debouncer: the debounced value takes the synchronized value on the edge where the two have differed for DEBOUNCE_CYCLES consecutive edges; any agreeing sample clears the counter.
REQ-006 For each button, a one-cycle press pulse SHALL be registered on a rising edge of the debounced value; releases SHALL generate no pulse.
REQ-007 Registered outputs SHALL change exactly DEBOUNCE_CYCLES+4 edges after a clean raw button rise is first sampled.
REQ-008 The FSM SHALL have states CLOCK, ADJ_HOUR, ADJ_MIN, ADJ_AHOUR, ADJ_AMIN and ALARM; mode_led bits [0..5] SHALL map to them in that order.
REQ-009 In CLOCK, a btnC pulse SHALL move the FSM to ADJ_HOUR.
REQ-010 In CLOCK, a rising edge of registered alarm_match SHALL move the FSM to ADJ_ALARM, i.e. state ALARM; a level held high after dismissal SHALL NOT re-enter ALARM.
REQ-011 In any ADJ_* state, a btnC pulse SHALL return the FSM to CLOCK.
REQ-012 In any ADJ_* state, a btnR pulse SHALL step HOUR->MIN->AHOUR->AMIN->HOUR, and a btnL pulse SHALL step in the reverse order.
REQ-013 If btnL and btnR pulses occur in the same cycle, the state SHALL NOT move.
REQ-014 In an ADJ_* state, a btnU pulse SHALL assert that state's adjust strobe for exactly one cycle with updown=1; a btnD pulse SHALL do the same with updown=0.
REQ-015 If btnU and btnD pulses occur in the same cycle, no strobe SHALL be issued.
REQ-016 updown SHALL hold its last value between strobes.
REQ-017 When pulses coincide, priority SHALL be btnC > btnL/btnR > btnU/btnD; lower-priority pulses in that cycle SHALL be discarded.
REQ-018 In any ADJ_* state, alarm_match edges SHALL be ignored.
REQ-019 en_en SHALL be 1 only in CLOCK and ALARM.
REQ-020 segment_display_flag SHALL be 1 only in ADJ_AHOUR and ADJ_AMIN.
REQ-021 alarm_active SHALL be 1 only in ALARM.
REQ-022 In ALARM, any button pulse SHALL return the FSM to CLOCK, and that pulse SHALL cause no other action.
REQ-023 In ALARM, a 14-bit timeout counter SHALL start at 0 on entry and increment each cycle; on reaching ALARM_TIMEOUT-1 it SHALL return the FSM to CLOCK.
REQ-024 Adjust strobes SHALL never be asserted outside ADJ_* states, and at most one strobe SHALL be high in any cycle.

Reset
REQ-025 While rst=0 at an edge, the block SHALL reset to: state CLOCK, en_en=1, all strobes 0, updown=1, segment_display_flag=0, alarm_active=0, mode_led=6'b000001.
REQ-026 The same reset SHALL clear synchronizers, debounced values, pulses, debounce counters, the timeout counter and the registered alarm_match.
REQ-027 A reset applied mid-debounce or mid-alarm SHALL discard the pending press or timeout; a button held through reset release SHALL generate a pulse only after debouncing completes.

Verification
REQ-028 Press btnC cleanly from reset: mode_led=000010, en_en=0 exactly 8 edges after the press is first sampled.
REQ-029 In ADJ_MIN, press btnD: adjust_en_min=1 for exactly one cycle with updown=0, and no other strobe is asserted.
REQ-030 Apply a btnU glitch of 3 cycles with DEBOUNCE_CYCLES=4: no strobe and no state change.
REQ-031 In ADJ_AMIN, press btnR: state becomes ADJ_HOUR and segment_display_flag goes 1 -> 0.
REQ-032 In CLOCK, raise alarm_match and hold it high for 200 cycles, then press btnU at cycle 50: alarm_active=1 from cycle 2, CLOCK restored after the press, no re-entry while alarm_match stays high, and no strobe is issued.
REQ-033 Enter ALARM with no button pressed: alarm_active drops after exactly 12000 cycles; assert rst=0 mid-alarm and the next edge gives the full reset state.
